// File: rtl/program_sequencer_dbg.sv
// Program sequencer with run/halt/single-step debug control, PC breakpoint and
// a saturating executed-instruction counter.
module program_sequencer_dbg #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_reset,
    input  logic             jmp,
    input  logic             jmp_nz,
    input  logic [3:0]       ir_nibble,
    input  logic             dont_jmp,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic [PC_W-1:0]  pm_addr,
    output logic [PC_W-1:0]  pc,
    output logic             hold,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] instr_count,
    output logic [7:0]       from_PS
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } dbg_state_t;

    dbg_state_t state;
    logic       bp_armed;
    logic       bp_hit;
    logic       leaving_halt;
    logic [PC_W-1:0] jump_target;

    assign jump_target = PC_W'({ir_nibble, 4'h0});
    assign bp_hit      = bp_en && bp_armed && (pc == bp_addr) && (state == RUN);
    assign hold        = sync_reset ? 1'b0
                                    : ((state == HALT) || bp_hit || ((state == RUN) && halt_req));

    // Any exit from HALT disarms the breakpoint so the trapped instruction can execute.
    assign leaving_halt = (state == HALT) && (sync_reset || resume_req || step_req);

    assign dbg_state = state;
    assign from_PS   = 8'h00;

    always_comb begin
        pm_addr = pc + PC_W'(1);
        if (sync_reset)
            pm_addr = '0;
        else if (hold)
            pm_addr = pc;
        else if (jmp || (jmp_nz && !dont_jmp))
            pm_addr = jump_target;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc <= '0;
        else
            pc <= pm_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else if (sync_reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= (bp_hit || halt_req) ? HALT : RUN;
                HALT:    begin
                    if (resume_req)
                        state <= RUN;
                    else if (step_req)
                        state <= STEP;
                    else
                        state <= HALT;
                end
                STEP:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bp_armed <= 1'b1;
        else if (leaving_halt)
            bp_armed <= 1'b0;
        else if (pc != bp_addr)
            bp_armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instr_count <= '0;
        else if (sync_reset)
            instr_count <= '0;
        else if (!hold && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_program_sequencer_dbg.sv
// Directed and randomized checks of program_sequencer_dbg against a cycle-level
// behavioural model of the sequencing and debug rules.
module tb_program_sequencer_dbg;

    logic       clk = 1'b0;
    logic       reset_n, sync_reset, jmp, jmp_nz, dont_jmp;
    logic [3:0] ir_nibble;
    logic       halt_req, step_req, resume_req, bp_en;
    logic [7:0] bp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic       hold;
    logic [1:0] dbg_state;
    logic [15:0] instr_count;

    logic [7:0] sat_pm_addr, sat_pc, sat_from_PS;
    logic       sat_hold;
    logic [1:0] sat_dbg_state;
    logic [3:0] sat_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pc, m_state, m_cnt;
    bit m_armed;

    program_sequencer_dbg #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .ir_nibble(ir_nibble), .dont_jmp(dont_jmp), .halt_req(halt_req), .step_req(step_req),
        .resume_req(resume_req), .bp_en(bp_en), .bp_addr(bp_addr), .pm_addr(pm_addr), .pc(pc),
        .hold(hold), .dbg_state(dbg_state), .instr_count(instr_count), .from_PS(from_PS)
    );

    // Narrow counter instance so saturation is reachable in a short run
    program_sequencer_dbg #(.PC_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .ir_nibble(ir_nibble), .dont_jmp(dont_jmp), .halt_req(halt_req), .step_req(step_req),
        .resume_req(resume_req), .bp_en(bp_en), .bp_addr(bp_addr), .pm_addr(sat_pm_addr),
        .pc(sat_pc), .hold(sat_hold), .dbg_state(sat_dbg_state), .instr_count(sat_count),
        .from_PS(sat_from_PS)
    );

    always #5 clk = ~clk;

    task automatic idle();
        sync_reset = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; ir_nibble = 4'h0;
        halt_req = 0; step_req = 0; resume_req = 0; bp_en = 0; bp_addr = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        tick();
        tick();
        #1;
        checks++;
        if (pc !== 8'h00 || dbg_state !== 2'b00 || instr_count !== 16'd0 || hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: pc=%h st=%b cnt=%0d hold=%b expected 00/00/0/0",
                     pc, dbg_state, instr_count, hold);
        end
        reset_n = 1;
        checks++;
        if (from_PS !== 8'h00) begin
            errors++;
            $display("[TB] FAIL from_PS: got %h expected 00", from_PS);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (pc !== 8'(i) || hold !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_pc: pc=%h hold=%b expected pc=%h hold=0", pc, hold, 8'(i));
            end
            tick();
        end
        checks++;
        if (pc !== 8'h05 || instr_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL seq_count: pc=%h cnt=%0d expected 05/5", pc, instr_count);
        end
    endtask

    task automatic test_jump();
        jmp = 1; ir_nibble = 4'h3;
        #1;
        checks++;
        if (pm_addr !== 8'h30) begin
            errors++;
            $display("[TB] FAIL jmp_addr: got %h expected 30", pm_addr);
        end
        tick();
        jmp = 0;
        checks++;
        if (pc !== 8'h30) begin
            errors++;
            $display("[TB] FAIL jmp_pc: got %h expected 30", pc);
        end
    endtask

    task automatic test_jmp_nz();
        jmp_nz = 1; ir_nibble = 4'hA; dont_jmp = 1;
        #1;
        checks++;
        if (pm_addr !== 8'h31) begin
            errors++;
            $display("[TB] FAIL jnz_not_taken: got %h expected 31", pm_addr);
        end
        tick();
        dont_jmp = 0;
        #1;
        checks++;
        if (pm_addr !== 8'hA0) begin
            errors++;
            $display("[TB] FAIL jnz_taken: got %h expected a0", pm_addr);
        end
        tick();
        checks++;
        if (pc !== 8'hA0) begin
            errors++;
            $display("[TB] FAIL jnz_pc: got %h expected a0", pc);
        end
        jmp = 1; dont_jmp = 1; ir_nibble = 4'h2;
        #1;
        checks++;
        if (pm_addr !== 8'h20) begin
            errors++;
            $display("[TB] FAIL jmp_and_jnz: got %h expected 20", pm_addr);
        end
        tick();
        idle();
    endtask

    task automatic test_wrap();
        jmp = 1; ir_nibble = 4'hF;
        tick();
        jmp = 0;
        repeat (15) tick();
        #1;
        checks++;
        if (pc !== 8'hFF || pm_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL wrap_addr: pc=%h pm_addr=%h expected ff/00", pc, pm_addr);
        end
        tick();
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL wrap_pc: got %h expected 00", pc);
        end
    endtask

    task automatic test_breakpoint();
        sync_reset = 1;
        tick();
        sync_reset = 0; bp_en = 1; bp_addr = 8'h04;
        repeat (4) tick();
        #1;
        checks++;
        if (pc !== 8'h04 || hold !== 1'b1 || pm_addr !== 8'h04) begin
            errors++;
            $display("[TB] FAIL bp_hit: pc=%h hold=%b pm_addr=%h expected 04/1/04", pc, hold, pm_addr);
        end
        tick();
        tick();
        checks++;
        if (dbg_state !== 2'b01 || pc !== 8'h04 || instr_count !== 16'd4) begin
            errors++;
            $display("[TB] FAIL bp_halt: st=%b pc=%h cnt=%0d expected 01/04/4", dbg_state, pc, instr_count);
        end
        step_req = 1;
        tick();
        step_req = 0;
        #1;
        checks++;
        if (dbg_state !== 2'b10 || hold !== 1'b0 || pm_addr !== 8'h05) begin
            errors++;
            $display("[TB] FAIL step_cycle: st=%b hold=%b pm_addr=%h expected 10/0/05", dbg_state, hold, pm_addr);
        end
        step_req = 1;
        tick();
        step_req = 0;
        checks++;
        if (dbg_state !== 2'b01 || pc !== 8'h05 || instr_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL step_done: st=%b pc=%h cnt=%0d expected 01/05/5", dbg_state, pc, instr_count);
        end
        resume_req = 1; step_req = 1;
        tick();
        resume_req = 0; step_req = 0;
        #1;
        checks++;
        if (dbg_state !== 2'b00 || hold !== 1'b0 || pc !== 8'h05) begin
            errors++;
            $display("[TB] FAIL resume_wins: st=%b hold=%b pc=%h expected 00/0/05", dbg_state, hold, pc);
        end
        tick();
        jmp = 1; ir_nibble = 4'h0;
        tick();
        jmp = 0;
        repeat (5) tick();
        checks++;
        if (dbg_state !== 2'b01 || pc !== 8'h04) begin
            errors++;
            $display("[TB] FAIL bp_retrap: st=%b pc=%h expected 01/04", dbg_state, pc);
        end
        resume_req = 1;
        tick();
        resume_req = 0;
        #1;
        checks++;
        if (dbg_state !== 2'b00 || hold !== 1'b0 || pc !== 8'h04) begin
            errors++;
            $display("[TB] FAIL bp_disarmed: st=%b hold=%b pc=%h expected 00/0/04", dbg_state, hold, pc);
        end
        tick();
        checks++;
        if (pc !== 8'h05 || dbg_state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_pass: pc=%h st=%b expected 05/00", pc, dbg_state);
        end
        bp_en = 0;
    endtask

    task automatic test_halt_and_sync_reset();
        halt_req = 1; jmp = 1; ir_nibble = 4'h7;
        #1;
        checks++;
        if (hold !== 1'b1 || pm_addr !== 8'h05) begin
            errors++;
            $display("[TB] FAIL halt_over_jmp: hold=%b pm_addr=%h expected 1/05", hold, pm_addr);
        end
        tick();
        halt_req = 0; jmp = 0;
        checks++;
        if (dbg_state !== 2'b01 || pc !== 8'h05) begin
            errors++;
            $display("[TB] FAIL halt_req: st=%b pc=%h expected 01/05", dbg_state, pc);
        end
        sync_reset = 1;
        #1;
        checks++;
        if (pm_addr !== 8'h00 || hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sreset_comb: pm_addr=%h hold=%b expected 00/0", pm_addr, hold);
        end
        tick();
        sync_reset = 0;
        checks++;
        if (dbg_state !== 2'b00 || instr_count !== 16'd0 || pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL sreset_state: st=%b cnt=%0d pc=%h expected 00/0/00", dbg_state, instr_count, pc);
        end
    endtask

    task automatic test_async_reset_step();
        repeat (3) tick();
        halt_req = 1;
        tick();
        halt_req = 0; step_req = 1;
        tick();
        step_req = 0;
        checks++;
        if (dbg_state !== 2'b10 || pc !== 8'h03) begin
            errors++;
            $display("[TB] FAIL pre_async: st=%b pc=%h expected 10/03", dbg_state, pc);
        end
        reset_n = 0;
        #1;
        checks++;
        if (pc !== 8'h00 || dbg_state !== 2'b00 || instr_count !== 16'd0 || hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: pc=%h st=%b cnt=%0d hold=%b expected 00/00/0/0",
                     pc, dbg_state, instr_count, hold);
        end
        tick();
        reset_n = 1;
    endtask

    task automatic test_saturation();
        idle();
        sync_reset = 1;
        tick();
        sync_reset = 0;
        repeat (15) tick();
        checks++;
        if (sat_count !== 4'hF) begin
            errors++;
            $display("[TB] FAIL sat_reach: got %0d expected 15", sat_count);
        end
        repeat (5) tick();
        checks++;
        if (sat_count !== 4'hF || instr_count !== 16'd20) begin
            errors++;
            $display("[TB] FAIL sat_hold: sat=%0d cnt=%0d expected 15/20", sat_count, instr_count);
        end
    endtask

    task automatic test_random();
        bit hit, e_hold;
        int e_addr, ns;
        idle();
        reset_n = 0;
        #1;
        reset_n = 1;
        m_pc = 0; m_state = 0; m_cnt = 0; m_armed = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sync_reset = ($urandom_range(0, 63) == 0);
            jmp        = ($urandom_range(0, 7) == 0);
            jmp_nz     = ($urandom_range(0, 7) == 0);
            dont_jmp   = $urandom_range(0, 1);
            ir_nibble  = 4'($urandom_range(0, 15));
            halt_req   = ($urandom_range(0, 15) == 0);
            step_req   = ($urandom_range(0, 3) == 0);
            resume_req = ($urandom_range(0, 7) == 0);
            bp_en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0)
                bp_addr = 8'($urandom_range(0, 20));
            #1;
            hit    = bp_en && m_armed && (m_pc == int'(bp_addr)) && (m_state == 0);
            e_hold = sync_reset ? 1'b0 : ((m_state == 1) || hit || (m_state == 0 && halt_req));
            if (sync_reset)
                e_addr = 0;
            else if (e_hold)
                e_addr = m_pc;
            else if (jmp || (jmp_nz && !dont_jmp))
                e_addr = int'(ir_nibble) * 16;
            else
                e_addr = (m_pc + 1) % 256;
            checks++;
            if (pm_addr !== 8'(e_addr) || hold !== e_hold || pc !== 8'(m_pc)
                || dbg_state !== 2'(m_state) || instr_count !== 16'(m_cnt)) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d: pm_addr=%h hold=%b pc=%h st=%b cnt=%0d expected %h/%b/%h/%b/%0d",
                         cyc, pm_addr, hold, pc, dbg_state, instr_count,
                         8'(e_addr), e_hold, 8'(m_pc), 2'(m_state), m_cnt);
            end
            if (sync_reset)
                ns = 0;
            else if (m_state == 0)
                ns = (hit || halt_req) ? 1 : 0;
            else if (m_state == 1)
                ns = resume_req ? 0 : (step_req ? 2 : 1);
            else
                ns = 1;
            if (m_state == 1 && ns != 1)
                m_armed = 0;
            else if (m_pc != int'(bp_addr))
                m_armed = 1;
            if (sync_reset)
                m_cnt = 0;
            else if (!e_hold && m_cnt < 65535)
                m_cnt++;
            m_pc = e_addr;
            m_state = ns;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_jmp_nz();
        test_wrap();
        test_breakpoint();
        test_halt_and_sync_reset();
        test_async_reset_step();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
